// File: rtl/simon_pad_arbiter.sv
// simon_pad_arbiter
// Owns the four shared Simon pads (lights and tone) and the raw player buttons.
// Simon playback gets the pads during Simon's turn; otherwise the player does,
// through a synchroniser, debounce, minimum-hold and release-lockout FSM that
// emits one clean player_pressed strobe per press-release cycle.
//
// Optional build macro: SIMON_GAMEOVER_FLASH_EN
//    defined     - pad_light flashes 1111/0000 with a FLASH_TICKS half-period while game over
//    not defined - pad_light stays dark while game over; no flash counter is built
//
// state     | meaning
// ----------+----------------------------------------------------------------
// SIMON     | Simon owns the pads; buttons ignored (also the reset state)
// GAMEOVER  | game ended; pads owned by Simon, sticky until reset_n
// P_IDLE    | player owns pads, waiting for exactly one button
// P_DEB     | candidate button must stay stable for DEB_TICKS cycles
// P_HOLD    | accepted pad lit with tone; stays at least HOLD_TICKS, until release
// P_RELEASE | all buttons must read released for DEB_TICKS cycles before re-arming

module simon_pad_arbiter #(
   parameter int DEB_TICKS   = 3,
   parameter int HOLD_TICKS  = 15,
   parameter int FLASH_TICKS = 30
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] btn,
   input  logic       simon_turn,
   input  logic [1:0] simon_num,
   input  logic       simon_pressed,
   input  logic       game_over,
   output logic [1:0] player_num,
   output logic       player_pressed,
   output logic [3:0] pad_light,
   output logic       tone_en,
   output logic [1:0] tone_num,
   output logic       pad_owner,
   output logic       multi_err
);

   localparam int MAX_DH = (DEB_TICKS > HOLD_TICKS) ? DEB_TICKS : HOLD_TICKS;
   localparam int MAX_T  = (MAX_DH > FLASH_TICKS) ? MAX_DH : FLASH_TICKS;
   localparam int CNT_W  = $clog2(MAX_T + 1);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_TICKS - 1);
   localparam logic [CNT_W-1:0] HOLD_MIN  = CNT_W'(HOLD_TICKS);

   typedef enum logic [2:0] {
      SIMON,
      GAMEOVER,
      P_IDLE,
      P_DEB,
      P_HOLD,
      P_RELEASE
   } state_t;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      onehot4 = 4'b0001 << idx;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cand_q, cand_d;
   logic [1:0]       pnum_q, pnum_d;
   logic             pp_q, pp_d;
   logic             multi_prev_q, multi_err_q;
   logic [3:0]       sync1_q, btn_s_q;

   logic             go_mode;
   logic             btn_multi;
   logic             btn_single;
   logic [1:0]       btn_idx;
   logic             multi_now;
   logic [3:0]       flash_light;

   // Two-flop synchroniser for the asynchronous board buttons.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q <= '0;
         btn_s_q <= '0;
      end else begin
         sync1_q <= btn;
         btn_s_q <= sync1_q;
      end
   end

   assign go_mode    = game_over | (state_q == GAMEOVER);
   assign btn_multi  = (btn_s_q & (btn_s_q - 4'd1)) != 4'd0;
   assign btn_single = (btn_s_q != 4'd0) && !btn_multi;
   assign multi_now  = !go_mode && !simon_turn && (state_q == P_IDLE) && btn_multi;

   // Index of the (single) pressed synchronised button.
   always_comb begin
      btn_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (btn_s_q[i]) btn_idx = i[1:0];
      end
   end

`ifdef SIMON_GAMEOVER_FLASH_EN
   logic [CNT_W-1:0] flash_cnt_q;
   logic             flash_on_q;
   localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_TICKS - 1);

   // Game-over flash timer; parked in the lit phase so the first game_over cycle shows 1111.
   always_ff @(posedge clk) begin
      if (!reset_n || !go_mode) begin
         flash_cnt_q <= '0;
         flash_on_q  <= 1'b1;
      end else if (flash_cnt_q == FLASH_LAST) begin
         flash_cnt_q <= '0;
         flash_on_q  <= ~flash_on_q;
      end else begin
         flash_cnt_q <= flash_cnt_q + 1'b1;
      end
   end

   assign flash_light = flash_on_q ? 4'b1111 : 4'b0000;
`else
   assign flash_light = 4'b0000;
`endif

   // State, counter and strobe registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= SIMON;
         cnt_q        <= '0;
         cand_q       <= 2'd0;
         pnum_q       <= 2'd0;
         pp_q         <= 1'b0;
         multi_prev_q <= 1'b0;
         multi_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cand_q       <= cand_d;
         pnum_q       <= pnum_d;
         pp_q         <= pp_d;
         multi_prev_q <= multi_now;
         multi_err_q  <= multi_now & ~multi_prev_q;
      end
   end

   // Next-state logic: game over beats Simon's turn, which beats the player FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      pnum_d  = pnum_q;
      pp_d    = 1'b0;

      if (go_mode) begin
         state_d = GAMEOVER;
         cnt_d   = '0;
      end else if (simon_turn) begin
         state_d = SIMON;
         cnt_d   = '0;
      end else begin
         case (state_q)
            SIMON: begin
               // A button held across the turn change must be released first.
               state_d = P_RELEASE;
               cnt_d   = '0;
            end
            P_IDLE: begin
               cnt_d = '0;
               if (btn_single) begin
                  cand_d  = btn_idx;
                  cnt_d   = CNT_W'(1);
                  state_d = P_DEB;
               end
            end
            P_DEB: begin
               if (btn_s_q == onehot4(cand_q)) begin
                  if (cnt_q >= DEB_LAST) begin
                     pnum_d  = cand_q;
                     pp_d    = 1'b1;
                     cnt_d   = '0;
                     state_d = P_HOLD;
                  end else begin
                     cnt_d = sat_inc(cnt_q);
                  end
               end else begin
                  cnt_d   = '0;
                  state_d = P_IDLE;
               end
            end
            P_HOLD: begin
               if ((cnt_q >= HOLD_MIN) && (btn_s_q == 4'd0)) begin
                  cnt_d   = '0;
                  state_d = P_RELEASE;
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            P_RELEASE: begin
               if (btn_s_q == 4'd0) begin
                  if (cnt_q >= DEB_LAST) begin
                     cnt_d   = '0;
                     state_d = P_IDLE;
                  end else begin
                     cnt_d = sat_inc(cnt_q);
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // Pad, tone and ownership outputs; the strobe is masked whenever Simon owns the pads.
   always_comb begin
      pad_light      = 4'b0000;
      tone_en        = 1'b0;
      tone_num       = 2'd0;
      pad_owner      = 1'b0;
      player_pressed = 1'b0;

      if (go_mode) begin
         pad_owner = 1'b1;
         pad_light = flash_light;
      end else if (simon_turn) begin
         pad_owner = 1'b1;
         pad_light = simon_pressed ? onehot4(simon_num) : 4'b0000;
         tone_en   = simon_pressed;
         tone_num  = simon_num;
      end else begin
         pad_owner      = (state_q == SIMON);
         player_pressed = pp_q;
         if (state_q == P_HOLD) begin
            pad_light = onehot4(pnum_q);
            tone_en   = 1'b1;
            tone_num  = pnum_q;
         end
      end
   end

   assign player_num = pnum_q;
   assign multi_err  = multi_err_q;

endmodule

// File: tb/tb_simon_pad_arbiter.sv
// Directed bench for simon_pad_arbiter with default parameters
// (DEB_TICKS=3, HOLD_TICKS=15, FLASH_TICKS=30).

module tb_simon_pad_arbiter;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] btn = 4'b0000;
   logic       simon_turn = 1'b0;
   logic [1:0] simon_num = 2'd0;
   logic       simon_pressed = 1'b0;
   logic       game_over = 1'b0;
   logic [1:0] player_num;
   logic       player_pressed;
   logic [3:0] pad_light;
   logic       tone_en;
   logic [1:0] tone_num;
   logic       pad_owner;
   logic       multi_err;

   int checks = 0;
   int errors = 0;

   simon_pad_arbiter dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .btn            (btn),
      .simon_turn     (simon_turn),
      .simon_num      (simon_num),
      .simon_pressed  (simon_pressed),
      .game_over      (game_over),
      .player_num     (player_num),
      .player_pressed (player_pressed),
      .pad_light      (pad_light),
      .tone_en        (tone_en),
      .tone_num       (tone_num),
      .pad_owner      (pad_owner),
      .multi_err      (multi_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Runs n cycles, counting strobes, first strobe cycle (1-based) and multi_err pulses.
   task automatic watch(input int n, output int pulses, output int first_k, output int multis);
      pulses  = 0;
      first_k = 0;
      multis  = 0;
      for (int k = 1; k <= n; k++) begin
         tick(1);
         if (player_pressed) begin
            pulses++;
            if (first_k == 0) first_k = k;
         end
         if (multi_err) multis++;
      end
   endtask

   initial begin
      int p, f, m, p2;
      logic [3:0] exp_flash;

      // Reset state
      tick(3);
      chk("rst_owner", pad_owner, 1);
      chk("rst_light", pad_light, 0);
      chk("rst_tone", tone_en, 0);
      chk("rst_pp", player_pressed, 0);
      chk("rst_pnum", player_num, 0);
      chk("rst_multi", multi_err, 0);

      // Simon playback; player button ignored
      reset_n = 1'b1;
      simon_turn = 1'b1;
      simon_num = 2'd2;
      simon_pressed = 1'b1;
      btn = 4'b0001;
      #1;
      chk("simon_light", pad_light, 4'b0100);
      chk("simon_tone", tone_en, 1);
      chk("simon_tnum", tone_num, 2);
      chk("simon_owner", pad_owner, 1);
      watch(12, p, f, m);
      chk("simon_no_press", p, 0);
      simon_pressed = 1'b0;
      #1;
      chk("simon_dark", pad_light, 0);
      chk("simon_tone_off", tone_en, 0);

      // Hand pads to the player
      simon_turn = 1'b0;
      btn = 4'b0000;
      tick(10);
      chk("player_owner", pad_owner, 0);

      // Press pad 3 held for 40 cycles
      btn = 4'b1000;
      watch(40, p, f, m);
      chk("p3_pulses", p, 1);
      chk("p3_latency", f, 5);
      chk("p3_num", player_num, 3);
      chk("p3_light", pad_light, 4'b1000);
      chk("p3_tone", tone_en, 1);
      chk("p3_tnum", tone_num, 3);
      chk("p3_multi", m, 0);
      btn = 4'b0000;
      tick(2);
      chk("p3_light_held", pad_light, 4'b1000);
      tick(2);
      chk("p3_light_off", pad_light, 0);
      chk("p3_tone_off", tone_en, 0);
      tick(8);

      // Two-cycle glitch on pad 1
      btn = 4'b0010;
      tick(2);
      btn = 4'b0000;
      watch(12, p, f, m);
      chk("glitch_pulses", p, 0);
      chk("glitch_light", pad_light, 0);

      // Two buttons, then a single one
      btn = 4'b0101;
      watch(8, p, f, m);
      chk("multi_pulses", m, 1);
      chk("multi_no_press", p, 0);
      btn = 4'b0100;
      watch(30, p, f, m);
      chk("p2_pulses", p, 1);
      chk("p2_latency", f, 5);
      chk("p2_num", player_num, 2);
      chk("p2_multi", m, 0);
      btn = 4'b0000;
      tick(20);

      // Release bounce must not re-trigger
      btn = 4'b1000;
      watch(25, p, f, m);
      btn = 4'b0000;
      tick(1);
      btn = 4'b1000;
      tick(1);
      btn = 4'b0000;
      watch(15, p2, f, m);
      chk("bounce_pulses", p + p2, 1);
      chk("bounce_num", player_num, 3);
      chk("bounce_light", pad_light, 0);

      // Simon's turn arrives mid-debounce
      btn = 4'b0001;
      tick(3);
      simon_turn = 1'b1;
      #1;
      chk("abort_owner", pad_owner, 1);
      watch(10, p, f, m);
      chk("abort_pulses", p, 0);
      chk("abort_num", player_num, 3);
      simon_turn = 1'b0;
      watch(20, p, f, m);
      chk("held_across_pulses", p, 0);
      chk("held_across_light", pad_light, 0);
      btn = 4'b0000;
      tick(8);

      // Game over
      btn = 4'b0001;
      game_over = 1'b1;
      #1;
      chk("go_owner", pad_owner, 1);
      p = 0;
      for (int i = 0; i < 60; i++) begin
`ifdef SIMON_GAMEOVER_FLASH_EN
         exp_flash = (i < 30) ? 4'b1111 : 4'b0000;
`else
         exp_flash = 4'b0000;
`endif
         chk("go_light", pad_light, exp_flash);
         if (player_pressed) p++;
         tick(1);
      end
      chk("go_pulses", p, 0);
      chk("go_tone", tone_en, 0);
      game_over = 1'b0;
      watch(10, p, f, m);
      chk("go_sticky_owner", pad_owner, 1);
      chk("go_sticky_pulses", p, 0);

      // Reset recovers
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      btn = 4'b0000;
      #1;
      chk("post_rst_num", player_num, 0);
      chk("post_rst_owner", pad_owner, 1);
      chk("post_rst_light", pad_light, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
